// File: rtl/ddr_fifo_traffic_sequencer.sv
// Sequences one DDR FIFO test run: prefill, concurrent stream, drain, with a 48-bit counting pattern.
// Optional macro TSEQ_ERR_STOP_EN adds chk_error and an ERROR state that halts the run on checker errors.
module ddr_fifo_traffic_sequencer #(
   parameter logic [31:0] PREFILL_WORDS = 32'd256,
   parameter logic [31:0] DATA_SEED     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
`ifdef TSEQ_ERR_STOP_EN
   input  logic [5:0]  chk_error,
`endif
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] cfg_words,
   input  logic        wr_full,
   output logic        wr_en,
   output logic [47:0] wr_data,
   input  logic        rd_empty,
   output logic        rd_en,
   output logic        busy,
   output logic        done,
   output logic [2:0]  state,
   output logic [31:0] wr_count,
   output logic [31:0] rd_count,
   output logic [31:0] run_cycles
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PREFILL = 3'd1,
      ST_STREAM  = 3'd2,
      ST_DRAIN   = 3'd3,
`ifdef TSEQ_ERR_STOP_EN
      ST_ERROR   = 3'd5,
`endif
      ST_DONE    = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_cfg_words;
   logic [31:0] r_pat;
   logic [31:0] r_wr_count;
   logic [31:0] r_rd_count;
   logic [31:0] r_run_cycles;
   logic        w_err;
   logic        w_start_ok;
   logic        w_wr_state;
   logic        w_rd_state;
   logic [32:0] w_wr_sum;
   logic [32:0] w_rd_sum;
   logic [32:0] w_prefill_target;

`ifdef TSEQ_ERR_STOP_EN
   assign w_err = (chk_error != 6'd0);
`else
   assign w_err = 1'b0;
`endif

   assign w_wr_state = (r_state == ST_PREFILL) || (r_state == ST_STREAM);
   assign w_rd_state = (r_state == ST_STREAM) || (r_state == ST_DRAIN);

   // Strobes respond to wr_full/rd_empty/abort in the same cycle, no registering.
   assign wr_en = w_wr_state && !wr_full && (r_wr_count < r_cfg_words) && !abort && !w_err;
   assign rd_en = w_rd_state && !rd_empty && (r_rd_count < r_wr_count) && !abort && !w_err;

   // 33-bit sums so count+strobe never wraps when cfg_words is near 2^32-1.
   assign w_wr_sum         = {1'b0, r_wr_count} + {32'd0, wr_en};
   assign w_rd_sum         = {1'b0, r_rd_count} + {32'd0, rd_en};
   assign w_prefill_target = {1'b0, (PREFILL_WORDS < r_cfg_words) ? PREFILL_WORDS : r_cfg_words};

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      w_start_ok   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               w_start_ok   = 1'b1;
               w_state_next = (cfg_words == 32'd0) ? ST_DONE : ST_PREFILL;
            end
         end
         ST_PREFILL: begin
            busy = 1'b1;
            if (w_wr_sum >= w_prefill_target) begin
               w_state_next = ST_STREAM;
            end
         end
         ST_STREAM: begin
            busy = 1'b1;
            if (w_wr_sum == {1'b0, r_cfg_words}) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (w_rd_sum == {1'b0, r_cfg_words}) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done         = 1'b1;
            w_state_next = ST_IDLE;
         end
`ifdef TSEQ_ERR_STOP_EN
         ST_ERROR: begin
            w_state_next = ST_ERROR;
         end
`endif
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      // Abort outranks everything outside IDLE; checker errors only stop an active run.
      if (r_state != ST_IDLE) begin
         if (abort) begin
            w_state_next = ST_IDLE;
         end
`ifdef TSEQ_ERR_STOP_EN
         else if (w_err && busy) begin
            w_state_next = ST_ERROR;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cfg_words  <= 32'd0;
         r_pat        <= DATA_SEED;
         r_wr_count   <= 32'd0;
         r_rd_count   <= 32'd0;
         r_run_cycles <= 32'd0;
      end else if (w_start_ok) begin
         r_cfg_words  <= cfg_words;
         r_pat        <= DATA_SEED;
         r_wr_count   <= 32'd0;
         r_rd_count   <= 32'd0;
         r_run_cycles <= 32'd0;
      end else begin
         if (wr_en) begin
            r_wr_count <= r_wr_count + 32'd1;
            r_pat      <= r_pat + 32'd1;
         end
         if (rd_en) begin
            r_rd_count <= r_rd_count + 32'd1;
         end
         if (busy && (r_run_cycles != 32'hFFFF_FFFF)) begin
            r_run_cycles <= r_run_cycles + 32'd1;
         end
      end
   end

   assign state      = r_state;
   assign wr_data    = {r_pat[15:0], r_pat};
   assign wr_count   = r_wr_count;
   assign rd_count   = r_rd_count;
   assign run_cycles = r_run_cycles;

endmodule

// File: tb/tb_ddr_fifo_traffic_sequencer.sv
// Directed bench for ddr_fifo_traffic_sequencer (default build, optional checker-stop disabled).
`timescale 1ns/1ps
module tb_ddr_fifo_traffic_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [31:0] cfg_words;
   logic        wr_full;
   logic        rd_empty;
   logic        wr_en;
   logic        rd_en;
   logic        busy;
   logic        done;
   logic [47:0] wr_data;
   logic [2:0]  state;
   logic [31:0] wr_count;
   logic [31:0] rd_count;
   logic [31:0] run_cycles;

   // Second instance exercises the seed wrap with a tiny prefill.
   logic        d2_start;
   logic        d2_zero;
   logic [31:0] d2_cfg_words;
   logic        d2_wr_en;
   logic        d2_rd_en;
   logic        d2_busy;
   logic        d2_done;
   logic [47:0] d2_wr_data;
   logic [2:0]  d2_state;
   logic [31:0] d2_wr_count;
   logic [31:0] d2_rd_count;
   logic [31:0] d2_run_cycles;

   int          n_checks;
   int          n_errors;
   int          mon_wr;
   int          mon_rd;
   int          mon_done;
   int          pat_bad;
   int          full_viol;
   int          empty_viol;
   logic [31:0] exp_pat;
   logic [31:0] wc_before;
   logic [47:0] wrap_exp [4] = '{48'hFFFE_FFFF_FFFE, 48'hFFFF_FFFF_FFFF,
                                 48'h0000_0000_0000, 48'h0001_0000_0001};

   ddr_fifo_traffic_sequencer #(
      .PREFILL_WORDS (32'd256),
      .DATA_SEED     (32'h0000_0000)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .cfg_words  (cfg_words),
      .wr_full    (wr_full),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .rd_empty   (rd_empty),
      .rd_en      (rd_en),
      .busy       (busy),
      .done       (done),
      .state      (state),
      .wr_count   (wr_count),
      .rd_count   (rd_count),
      .run_cycles (run_cycles)
   );

   ddr_fifo_traffic_sequencer #(
      .PREFILL_WORDS (32'd2),
      .DATA_SEED     (32'hFFFF_FFFE)
   ) u_dut_wrap (
      .clk        (clk),
      .rst        (rst),
      .start      (d2_start),
      .abort      (d2_zero),
      .cfg_words  (d2_cfg_words),
      .wr_full    (d2_zero),
      .wr_en      (d2_wr_en),
      .wr_data    (d2_wr_data),
      .rd_empty   (d2_zero),
      .rd_en      (d2_rd_en),
      .busy       (d2_busy),
      .done       (d2_done),
      .state      (d2_state),
      .wr_count   (d2_wr_count),
      .rd_count   (d2_rd_count),
      .run_cycles (d2_run_cycles)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expected);
      n_checks++;
      if (obs !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expected);
      end
   endtask

   // One clock: observe strobes mid-cycle, then return 1ns after the rising edge.
   task automatic tick();
      @(negedge clk);
      if (!rst) begin
         if (wr_en) begin
            if (wr_data !== {exp_pat[15:0], exp_pat}) pat_bad++;
            if (wr_full) full_viol++;
            exp_pat++;
            mon_wr++;
         end
         if (rd_en) begin
            if (rd_empty) empty_viol++;
            mon_rd++;
         end
         if (done) mon_done++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic mon_clear();
      mon_wr     = 0;
      mon_rd     = 0;
      mon_done   = 0;
      pat_bad    = 0;
      full_viol  = 0;
      empty_viol = 0;
      exp_pat    = 32'h0000_0000;
   endtask

   task automatic begin_run(input logic [31:0] words);
      mon_clear();
      cfg_words = words;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles);
      int n;
      n = 0;
      while (mon_done == 0 && n < max_cycles) begin
         tick();
         n++;
      end
      check_eq("done_seen", 64'(mon_done), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b1;
      start        = 1'b0;
      abort        = 1'b0;
      cfg_words    = 32'd0;
      wr_full      = 1'b0;
      rd_empty     = 1'b0;
      d2_start     = 1'b0;
      d2_zero      = 1'b0;
      d2_cfg_words = 32'd0;
      wc_before    = 32'd0;
      mon_clear();
      repeat (3) tick();

      check_eq("rst_state", 64'(state), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_wr_en", 64'(wr_en), 64'd0);
      check_eq("rst_rd_en", 64'(rd_en), 64'd0);
      check_eq("rst_wr_count", 64'(wr_count), 64'd0);
      check_eq("rst_rd_count", 64'(rd_count), 64'd0);
      check_eq("rst_run_cycles", 64'(run_cycles), 64'd0);
      check_eq("rst_wr_data", 64'(wr_data), 64'd0);
      check_eq("rst_wr_data_seed", 64'(d2_wr_data), 64'hFFFE_FFFF_FFFE);
      rst = 1'b0;
      tick();

      // Basic run: 256 write-only cycles, 744 concurrent, 256 read-only.
      begin_run(32'd1000);
      check_eq("basic_prefill_state", 64'(state), 64'd1);
      check_eq("basic_first_wr_en", 64'(wr_en), 64'd1);
      check_eq("basic_first_word", 64'(wr_data), 64'd0);
      repeat (255) tick();
      check_eq("basic_still_prefill", 64'(state), 64'd1);
      check_eq("basic_prefill_no_rd", 64'(mon_rd), 64'd0);
      tick();
      check_eq("basic_stream_state", 64'(state), 64'd2);
      check_eq("basic_prefill_words", 64'(wr_count), 64'd256);
      wait_done(3000);
      repeat (3) tick();
      check_eq("basic_done_pulses", 64'(mon_done), 64'd1);
      check_eq("basic_wr_count", 64'(wr_count), 64'd1000);
      check_eq("basic_rd_count", 64'(rd_count), 64'd1000);
      check_eq("basic_run_cycles", 64'(run_cycles), 64'd1256);
      check_eq("basic_pattern", 64'(pat_bad), 64'd0);
      check_eq("basic_strobed_writes", 64'(mon_wr), 64'd1000);
      check_eq("basic_idle", 64'(state), 64'd0);
      $display("run basic: wr=%0d rd=%0d cycles=%0d", wr_count, rd_count, run_cycles);

      // Seed wrap on the second instance.
      d2_cfg_words = 32'd4;
      d2_start     = 1'b1;
      tick();
      d2_start     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_eq("wrap_wr_en", 64'(d2_wr_en), 64'd1);
         check_eq("wrap_data", 64'(d2_wr_data), 64'(wrap_exp[i]));
         tick();
      end
      check_eq("wrap_wr_stop", 64'(d2_wr_en), 64'd0);
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 20 && seen == 0; i++) begin
            if (d2_done) seen = 1;
            tick();
         end
         check_eq("wrap_done_seen", 64'(seen), 64'd1);
      end
      check_eq("wrap_rd_count", 64'(d2_rd_count), 64'd4);
      $display("run wrap: wr=%0d rd=%0d", d2_wr_count, d2_rd_count);

      // Small run below the prefill depth: 10 prefill + 1 stream + 9 drain cycles.
      begin_run(32'd10);
      repeat (9) tick();
      check_eq("small_prefill_state", 64'(state), 64'd1);
      tick();
      check_eq("small_stream_state", 64'(state), 64'd2);
      check_eq("small_prefill_words", 64'(wr_count), 64'd10);
      wait_done(100);
      check_eq("small_wr_count", 64'(wr_count), 64'd10);
      check_eq("small_rd_count", 64'(rd_count), 64'd10);
      check_eq("small_run_cycles", 64'(run_cycles), 64'd20);
      $display("run small: wr=%0d rd=%0d cycles=%0d", wr_count, rd_count, run_cycles);

      // Zero-length run goes straight to DONE and clears the counters.
      begin_run(32'd0);
      check_eq("zero_done_state", 64'(state), 64'd4);
      check_eq("zero_done_pulse", 64'(done), 64'd1);
      check_eq("zero_wr_count", 64'(wr_count), 64'd0);
      check_eq("zero_rd_count", 64'(rd_count), 64'd0);
      tick();
      check_eq("zero_idle", 64'(state), 64'd0);
      check_eq("zero_done_low", 64'(done), 64'd0);
      $display("run zero: wr=%0d rd=%0d", wr_count, rd_count);

      // Backpressure: 20-cycle full burst in STREAM, rd_empty toggling every cycle.
      begin_run(32'd1000);
      repeat (256) tick();
      check_eq("bp_stream_state", 64'(state), 64'd2);
      for (int c = 0; c < 4000 && mon_done == 0; c++) begin
         rd_empty = c[0];
         wr_full  = (c >= 100 && c < 120);
         if (c == 100) wc_before = wr_count;
         if (c == 120) check_eq("bp_full_hold", 64'(wr_count), 64'(wc_before));
         tick();
      end
      rd_empty = 1'b0;
      wr_full  = 1'b0;
      check_eq("bp_done_seen", 64'(mon_done), 64'd1);
      check_eq("bp_wr_count", 64'(wr_count), 64'd1000);
      check_eq("bp_rd_count", 64'(rd_count), 64'd1000);
      check_eq("bp_wr_while_full", 64'(full_viol), 64'd0);
      check_eq("bp_rd_while_empty", 64'(empty_viol), 64'd0);
      check_eq("bp_pattern", 64'(pat_bad), 64'd0);
      $display("run backpressure: wr=%0d rd=%0d cycles=%0d", wr_count, rd_count, run_cycles);

      // Ignored start mid-run, then abort at wr_count=500.
      begin_run(32'd1000);
      for (int i = 0; i < 400 && wr_count != 32'd300; i++) tick();
      cfg_words = 32'd5;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      cfg_words = 32'd1000;
      check_eq("ign_start_state", 64'(state), 64'd2);
      check_eq("ign_start_wr_count", 64'(wr_count), 64'd301);
      check_eq("ign_start_wr_en", 64'(wr_en), 64'd1);
      for (int i = 0; i < 400 && wr_count != 32'd500; i++) tick();
      check_eq("abort_at_500", 64'(wr_count), 64'd500);
      check_eq("abort_rd_before", 64'(rd_count), 64'd244);
      abort = 1'b1;
      #1;
      check_eq("abort_wr_en", 64'(wr_en), 64'd0);
      check_eq("abort_rd_en", 64'(rd_en), 64'd0);
      tick();
      abort = 1'b0;
      check_eq("abort_idle", 64'(state), 64'd0);
      check_eq("abort_wr_hold", 64'(wr_count), 64'd500);
      check_eq("abort_rd_hold", 64'(rd_count), 64'd244);
      repeat (3) tick();
      check_eq("abort_no_done", 64'(mon_done), 64'd0);
      $display("run abort: wr=%0d rd=%0d", wr_count, rd_count);

      // Synchronous reset in DRAIN discards the run.
      begin_run(32'd300);
      for (int i = 0; i < 1000 && state != 3'd3; i++) tick();
      check_eq("rstrun_drain_state", 64'(state), 64'd3);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      check_eq("rstrun_state", 64'(state), 64'd0);
      check_eq("rstrun_busy", 64'(busy), 64'd0);
      check_eq("rstrun_rd_en", 64'(rd_en), 64'd0);
      check_eq("rstrun_wr_count", 64'(wr_count), 64'd0);
      check_eq("rstrun_rd_count", 64'(rd_count), 64'd0);
      check_eq("rstrun_run_cycles", 64'(run_cycles), 64'd0);
      check_eq("rstrun_wr_data", 64'(wr_data), 64'd0);
      rst = 1'b0;
      repeat (3) tick();
      check_eq("rstrun_no_done", 64'(mon_done), 64'd0);
      $display("run reset: wr=%0d rd=%0d", wr_count, rd_count);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
